// File: rtl/hpc3_and_arb_pkg.sv
// Shared definitions for the HPC3 AND arbiter: id width helper and requester limits.
package hpc3_and_arb_pkg;

    localparam int unsigned MAX_NREQ = 16;

    // Requester id width; never narrower than one bit.
    function automatic int unsigned idw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpc3_and_module.sv
// One-bit first-order HPC3 masked AND gadget: one register stage, combinational output compression.
module hpc3_and_module (
    input  logic clk,
    input  logic x0,
    input  logic x1,
    input  logic y0,
    input  logic y1,
    input  logic a,
    input  logic b,
    output logic z0,
    output logic z1
);

    logic t00_q, t11_q, v01_q, w01_q, v10_q, w10_q;

    // Cross terms: v^w = x_i*y_j ^ a, with b blinding each register individually.
    always_ff @(posedge clk) begin
        t00_q <= x0 & y0;
        t11_q <= x1 & y1;
        v01_q <= (x0 & (y1 ^ a)) ^ b;
        w01_q <= (~x0 & a) ^ b;
        v10_q <= (x1 & (y0 ^ a)) ^ b;
        w10_q <= (~x1 & a) ^ b;
    end

    assign z0 = t00_q ^ v01_q ^ w01_q;
    assign z1 = t11_q ^ v10_q ^ w10_q;

endmodule

// File: rtl/hpc3_and_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr (mod NREQ), one-hot plus index.
module hpc3_and_rr_pick
    import hpc3_and_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int unsigned       off;
    int unsigned       sum;

    assign dbl = {req, req};
    assign rot = NREQ'(dbl >> ptr);

    always_comb begin
        found = 1'b0;
        off   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (rot[k] && !found) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = 32'(ptr) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        idx = IDW'(sum);
        grant = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant[i] = found && (idx == IDW'(i));
        end
    end

endmodule

// File: rtl/hpc3_and_arbiter.sv
// Round-robin arbiter sharing WIDTH bit-sliced HPC3 AND gadgets among NREQ requesters.
// Optional HPC3_ARB_ZERO_IDLE_EN: zero gadget inputs when idle and clear vacated result entries.
module hpc3_and_arbiter
    import hpc3_and_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned OUT_DEPTH = 2,
    localparam int unsigned IDW      = idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x0,
    input  logic [NREQ*WIDTH-1:0] req_x1,
    input  logic [NREQ*WIDTH-1:0] req_y0,
    input  logic [NREQ*WIDTH-1:0] req_y1,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    input  logic [WIDTH-1:0]      rnd_a,
    input  logic [WIDTH-1:0]      rnd_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH-1:0]      res_z0,
    output logic [WIDTH-1:0]      res_z1,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] z0;
        logic [WIDTH-1:0] z1;
    } entry_t;

    logic            run_q;
    logic [IDW-1:0]  ptr_q, ptr_nxt;
    logic            s1_valid_q;
    logic [IDW-1:0]  s1_id_q;
    logic [CW-1:0]   count_q, count_d, wr_idx;
    entry_t          mem_q [OUT_DEPTH];
    entry_t          mem_d [OUT_DEPTH];
    entry_t          s1_entry;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx, sel;
    logic             any_req, credit_ok, issue, pop;
    logic [WIDTH-1:0] op_x0, op_x1, op_y0, op_y1;
    logic [WIDTH-1:0] g_x0, g_x1, g_y0, g_y1, g_a, g_b;
    logic [WIDTH-1:0] s1_z0, s1_z1;

    hpc3_and_rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req  (req_valid),
        .ptr  (ptr_q),
        .grant(grant),
        .idx  (grant_idx),
        .found(any_req)
    );

    assign res_valid = (count_q != '0);
    assign pop       = res_valid & res_ready;
    // A head leaving this cycle frees its slot before the new op reaches the FIFO.
    assign credit_ok = (32'(count_q) + 32'(s1_valid_q)) < (OUT_DEPTH + 32'(pop));
    assign issue     = rst_n & run_q & any_req & rnd_valid & credit_ok;
    assign req_ready = {NREQ{issue}} & grant;
    assign rnd_ready = issue;
    assign busy      = s1_valid_q | res_valid;
    assign ptr_nxt   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

`ifdef HPC3_ARB_ZERO_IDLE_EN
    assign sel  = grant_idx;
    assign g_x0 = op_x0 & {WIDTH{issue}};
    assign g_x1 = op_x1 & {WIDTH{issue}};
    assign g_y0 = op_y0 & {WIDTH{issue}};
    assign g_y1 = op_y1 & {WIDTH{issue}};
    assign g_a  = rnd_a & {WIDTH{issue}};
    assign g_b  = rnd_b & {WIDTH{issue}};
`else
    logic [IDW-1:0] last_q;

    // Idle cycles keep the last granted requester on the mux to avoid needless toggling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (issue) begin
            last_q <= grant_idx;
        end
    end

    assign sel  = issue ? grant_idx : last_q;
    assign g_x0 = op_x0;
    assign g_x1 = op_x1;
    assign g_y0 = op_y0;
    assign g_y1 = op_y1;
    assign g_a  = rnd_a;
    assign g_b  = rnd_b;
`endif

    always_comb begin
        op_x0 = '0;
        op_x1 = '0;
        op_y0 = '0;
        op_y1 = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                op_x0 = req_x0[i*WIDTH +: WIDTH];
                op_x1 = req_x1[i*WIDTH +: WIDTH];
                op_y0 = req_y0[i*WIDTH +: WIDTH];
                op_y1 = req_y1[i*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_gadget
        hpc3_and_module u_and (
            .clk(clk),
            .x0 (g_x0[b]),
            .x1 (g_x1[b]),
            .y0 (g_y0[b]),
            .y1 (g_y1[b]),
            .a  (g_a[b]),
            .b  (g_b[b]),
            .z0 (s1_z0[b]),
            .z1 (s1_z1[b])
        );
    end

    assign s1_entry = '{id: s1_id_q, z0: s1_z0, z1: s1_z1};

    // Shift-register FIFO: slot 0 is always the head, so outputs come straight from flops.
    always_comb begin
        for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_idx = count_q - CW'(pop);
        if (pop) begin
            for (int unsigned i = 0; i + 1 < OUT_DEPTH; i++) begin
                mem_d[i] = mem_q[i+1];
            end
`ifdef HPC3_ARB_ZERO_IDLE_EN
            mem_d[OUT_DEPTH-1] = '0;
`endif
        end
        if (s1_valid_q) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    mem_d[i] = s1_entry;
                end
            end
        end
        count_d = count_q + CW'(s1_valid_q) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            run_q      <= 1'b1;
            s1_valid_q <= issue;
            if (issue) begin
                s1_id_q <= grant_idx;
                ptr_q   <= ptr_nxt;
            end
            count_q <= count_d;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign res_id = mem_q[0].id;
    assign res_z0 = mem_q[0].z0;
    assign res_z1 = mem_q[0].z1;

endmodule
